fir_inverse: RTL and testbench

Inverse (deconvolution) stage for the 4-tap FIR `fir_filter`, whose coefficients are H = [-2 -1 3 4]. It takes the filter's 16-bit output stream and reconstructs the original 8-bit input samples exactly, using the recursion x[n] = -(y[n] + x[n-1] - 3x[n-2] - 4x[n-3]) / 2. It sits at the receive end of a link that carries FIR-encoded samples. It is also used in loopback benches as a bit-exact checker for `fir_filter`. Integrity checks (parity and range) detect stream corruption and lose-sync conditions.

---
 rtl/fir_inverse.sv | 93 +++++++++
 tb/tb_fir_inverse.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fir_inverse.sv
// Deconvolution stage for the fixed 4-tap FIR H = [-2 -1 3 4]: rebuilds int8 samples from
// the 16-bit encoded stream, one sample per cycle, with sticky parity/range fault detection.
module fir_inverse (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_valid,
  input  logic signed [15:0] Yin,
  input  logic               Resync,
  output logic               Out_valid,
  output logic signed [7:0]  Xout,
  output logic [1:0]         Err
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;

  typedef enum logic {RUN, FAULT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x1, x2, x3;
  logic signed [ACC_W-1:0]  yin_e, x1_e, x2_e, x3_e;
  logic signed [ACC_W-1:0]  acc_p0, q_p0;
  logic                     accept_p0, par_f_p0, rng_f_p0;

  function automatic logic fits_int8(input logic signed [ACC_W-1:0] v);
    return (v >= -18'sd128) && (v <= 18'sd127);
  endfunction

  // Stage p0: recursion closes in one cycle through x1
  always_comb begin
    yin_e  = {{(ACC_W-16){Yin[15]}}, Yin};
    x1_e   = {{(ACC_W-DATA_W){x1[DATA_W-1]}}, x1};
    x2_e   = {{(ACC_W-DATA_W){x2[DATA_W-1]}}, x2};
    x3_e   = {{(ACC_W-DATA_W){x3[DATA_W-1]}}, x3};
    acc_p0 = yin_e + x1_e - 18'sd3 * x2_e - 18'sd4 * x3_e;
    q_p0   = -(acc_p0 >>> 1);
  end

  always_comb begin
    state_nxt = state;
    accept_p0 = 1'b0;
    par_f_p0  = 1'b0;
    rng_f_p0  = 1'b0;
    if (Resync) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (In_valid) begin
            par_f_p0 = acc_p0[0];
            rng_f_p0 = !fits_int8(q_p0);
            if (par_f_p0 || rng_f_p0) state_nxt = FAULT;
            else                      accept_p0 = 1'b1;
          end
        end
        FAULT: state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Stage p1: registered decode result, history and sticky faults
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= RUN;
      Out_valid <= 1'b0;
      Xout      <= '0;
      Err       <= 2'b00;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
    end else if (Resync) begin
      state     <= RUN;
      Out_valid <= 1'b0;
      Err       <= 2'b00;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
    end else begin
      state     <= state_nxt;
      Out_valid <= accept_p0;
      Err       <= Err | {rng_f_p0, par_f_p0};
      if (accept_p0) begin
        Xout <= q_p0[DATA_W-1:0];
        x3   <= x2;
        x2   <= x1;
        x1   <= q_p0[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fir_inverse.sv
// Directed vector table for fir_inverse plus a random loopback against a behavioural
// model of the [-2 -1 3 4] encoder.
module tb_fir_inverse;

  logic               Clk = 1'b0;
  logic               Rst = 1'b0;
  logic               In_valid = 1'b0;
  logic signed [15:0] Yin = '0;
  logic               Resync = 1'b0;
  logic               Out_valid;
  logic signed [7:0]  Xout;
  logic [1:0]         Err;

  int n_tests = 0;
  int n_fail  = 0;

  fir_inverse dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_valid  (In_valid),
    .Yin       (Yin),
    .Resync    (Resync),
    .Out_valid (Out_valid),
    .Xout      (Xout),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string              name;
    logic               rst;
    logic               resync;
    logic               vld;
    logic signed [15:0] y;
    logic               exp_ov;
    logic signed [7:0]  exp_x;
    logic [1:0]         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic rs, input logic v,
                     input int y, input logic ov, input int x, input logic [1:0] e);
    vec_t t;
    t.name = nm; t.rst = r; t.resync = rs; t.vld = v; t.y = 16'(y);
    t.exp_ov = ov; t.exp_x = 8'(x); t.exp_err = e;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic ov, input logic signed [7:0] x,
                       input logic [1:0] e);
    n_tests++;
    if (Out_valid !== ov || Xout !== x || Err !== e) begin
      n_fail++;
      $display("FAIL %s: got ov=%0b x=%0d err=%b, need ov=%0b x=%0d err=%b",
               nm, Out_valid, Xout, Err, ov, x, e);
    end
  endtask

  int xh1, xh2, xh3, xv, yv;
  logic signed [7:0] xs;

  initial begin
    // basic decode
    add("rst0",   1, 0, 0,    0, 0,    0, 2'b00);
    add("basic1", 0, 0, 1,   -2, 1,    1, 2'b00);
    add("basic2", 0, 0, 1,   -5, 1,    2, 2'b00);
    add("basic3", 0, 0, 1,   -5, 1,    3, 2'b00);
    add("basic4", 0, 0, 1,    7, 1,    0, 2'b00);
    add("basic_idle", 0, 0, 0, 0, 0,   0, 2'b00);
    // extremes
    add("rst1",   1, 0, 0,    0, 0,    0, 2'b00);
    add("max1",   0, 0, 1, -254, 1,  127, 2'b00);
    add("max2",   0, 0, 1, -381, 1,  127, 2'b00);
    add("max3",   0, 0, 1,    0, 1,  127, 2'b00);
    add("max4",   0, 0, 1,  508, 1,  127, 2'b00);
    add("rst2",   1, 0, 0,    0, 0,    0, 2'b00);
    add("min1",   0, 0, 1,  256, 1, -128, 2'b00);
    // parity fault, ignore, resync
    add("rst3",   1, 0, 0,    0, 0,    0, 2'b00);
    add("par",    0, 0, 1,   -3, 0,    0, 2'b01);
    add("par_ign1", 0, 0, 1, -2, 0,    0, 2'b01);
    add("par_ign2", 0, 0, 1,  5, 0,    0, 2'b01);
    add("par_resync", 0, 1, 0, 0, 0,   0, 2'b00);
    add("par_after", 0, 0, 1, -2, 1,   1, 2'b00);
    // range fault with nonzero Xout held, resync drops same-cycle sample
    add("rst4",   1, 0, 0,    0, 0,    0, 2'b00);
    add("rng_pre", 0, 0, 1,  -2, 1,    1, 2'b00);
    add("rng",    0, 0, 1, -259, 0,    1, 2'b10);
    add("rng_hold", 0, 0, 1, -2, 0,    1, 2'b10);
    add("rng_resync_drop", 0, 1, 1, -2, 0, 1, 2'b00);
    add("rng_no_ov", 0, 0, 0, 0, 0,    1, 2'b00);
    add("rng_after", 0, 0, 1, -4, 1,   2, 2'b00);
    // plain range fault from reset, then both faults together
    add("rst5",   1, 0, 0,    0, 0,    0, 2'b00);
    add("rng0",   0, 0, 1, -258, 0,    0, 2'b10);
    add("rst6",   1, 0, 0,    0, 0,    0, 2'b00);
    add("both",   0, 0, 1, -259, 0,    0, 2'b11);
    // gaps
    add("rst7",   1, 0, 0,    0, 0,    0, 2'b00);
    add("gap1",   0, 0, 1,   -2, 1,    1, 2'b00);
    add("gap_i1", 0, 0, 0,    0, 0,    1, 2'b00);
    add("gap2",   0, 0, 1,   -5, 1,    2, 2'b00);
    add("gap_i2", 0, 0, 0,    0, 0,    2, 2'b00);
    add("gap_i3", 0, 0, 0,    0, 0,    2, 2'b00);
    add("gap3",   0, 0, 1,   -5, 1,    3, 2'b00);
    add("gap_i4", 0, 0, 0,    0, 0,    3, 2'b00);
    add("gap4",   0, 0, 1,    7, 1,    0, 2'b00);
    // reset mid-stream
    add("rst8",   1, 0, 0,    0, 0,    0, 2'b00);
    add("mid1",   0, 0, 1,   -2, 1,    1, 2'b00);
    add("mid2",   0, 0, 1,   -5, 1,    2, 2'b00);
    add("mid_rst", 1, 0, 1,  -5, 0,    0, 2'b00);
    add("mid_re", 0, 0, 1,   -2, 1,    1, 2'b00);

    Rst = 1'b1;
    tick();
    tick();
    check("reset_state", 1'b0, 8'sd0, 2'b00);

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; Resync = vecs[i].resync;
      In_valid = vecs[i].vld; Yin = vecs[i].y;
      tick();
      check(vecs[i].name, vecs[i].exp_ov, vecs[i].exp_x, vecs[i].exp_err);
    end

    // random loopback: encoder model primed with zeros
    Rst = 1'b1; Resync = 1'b0; In_valid = 1'b0; Yin = '0;
    tick();
    Rst = 1'b0;
    xh1 = 0; xh2 = 0; xh3 = 0;
    for (int i = 0; i < 10004; i++) begin
      xs = (i < 4) ? 8'sd0 : 8'($urandom_range(0, 255));
      xv = int'(xs);
      yv = -2 * xv - xh1 + 3 * xh2 + 4 * xh3;
      In_valid = 1'b1;
      Yin = 16'(yv);
      tick();
      check("loopback", 1'b1, xs, 2'b00);
      xh3 = xh2; xh2 = xh1; xh1 = xv;
    end
    In_valid = 1'b0;
    tick();
    check("loopback_end", 1'b0, xs, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
